seq_scheduler: RTL and testbench

//  Multi-track step-sequencer controller: one shared tempo divider drives TRACKS bit-pattern tracks.

---
 rtl/seq_pkg.sv | 20 ++
 rtl/seq_divider.sv | 73 +++++++
 rtl/seq_scheduler.sv | 162 ++++++++++++++++
 tb/tb_seq_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared defaults and types for the step-sequencer controller.
//   DEF_TRACKS / DEF_DEPTH / DEF_DIVW : default track count, pattern depth, divider width
//   pat_t / len_t                     : pattern word (MSB = step 0) and length field
//   state_t                           : sequencer FSM state
package seq_pkg;

  localparam int DEF_TRACKS = 4;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_DIVW   = 24;
  localparam int DEF_LENW   = $clog2(DEF_DEPTH + 1);

  typedef logic [DEF_DEPTH-1:0] pat_t;
  typedef logic [DEF_LENW-1:0]  len_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// seq_divider: shared tempo counter for the step sequencer.
// Optional feature macro: SWING_EN (adds swing_amt; odd steps delayed).
// Ports:
//   clk, rst         clock, async active-high reset
//   ena              clock enable, freezes the counter when low
//   run              play level; low holds the counter (and swing phase) at 0
//   div              clocks per step, 0 behaves as 1
//   swing_amt        (SWING_EN only) odd-step delay in clocks, clamped to div-1
//   fire             combinational step pulse, registered by the top
module seq_divider
  import seq_pkg::*;
#(
  parameter int DIVW = DEF_DIVW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            run,
  input  logic [DIVW-1:0] div,
`ifdef SWING_EN
  input  logic [DIVW-1:0] swing_amt,
`endif
  output logic            fire
);

  logic [DIVW-1:0] cnt_q, cnt_d, last;

  assign last = (div == '0) ? '0 : div - DIVW'(1);

  // Compare against the current div every cycle; a shrunk div makes the
  // counter wrap immediately instead of running up to the full width.
  always_comb begin
    cnt_d = cnt_q;
    if (!run)
      cnt_d = '0;
    else if (cnt_q >= last)
      cnt_d = '0;
    else
      cnt_d = cnt_q + DIVW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (ena)
      cnt_q <= cnt_d;
  end

`ifdef SWING_EN
  logic            odd_q;
  logic [DIVW-1:0] swing_eff;

  assign swing_eff = (swing_amt > last) ? last : swing_amt;

  // Odd steps fire later inside their own period, so each even/odd pair
  // still spans exactly 2*div clocks.
  assign fire = ena && run && (odd_q ? (cnt_q == swing_eff) : (cnt_q == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      odd_q <= 1'b0;
    else if (ena) begin
      if (!run)
        odd_q <= 1'b0;
      else if (cnt_q >= last)
        odd_q <= ~odd_q;
    end
  end
`else
  assign fire = ena && run && (cnt_q == '0);
`endif

endmodule

// File: rtl/seq_scheduler.sv
// seq_scheduler: multi-track step-sequencer controller.
// Optional feature macro: SWING_EN (swing_amt port, odd-step delay).
// Ports:
//   clk, rst                 clock, async active-high reset
//   ena                      clock enable; low freezes state and zeroes pulses
//   run                      level, 1 = play
//   div                      clocks per step (0 behaves as 1)
//   swing_amt                (SWING_EN only) odd-step delay in clocks
//   wr_en/wr_track/wr_pat/wr_len  shadow pattern/length write
//   gate                     per-track one-cycle step trigger
//   step_tick, bar_tick      step pulse, global bar pulse
//   running                  1 while in RUN
//
// state | meaning
// IDLE  | stopped; shadow banks copied to active every enabled cycle
// RUN   | playing; steps fire from the divider, tracks update at own pos 0
module seq_scheduler
  import seq_pkg::*;
#(
  parameter  int TRACKS = DEF_TRACKS,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int DIVW   = DEF_DIVW,
  localparam int TRKW   = (TRACKS > 1) ? $clog2(TRACKS) : 1,
  localparam int LENW   = $clog2(DEPTH + 1),
  localparam int POSW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              run,
  input  logic [DIVW-1:0]   div,
`ifdef SWING_EN
  input  logic [DIVW-1:0]   swing_amt,
`endif
  input  logic              wr_en,
  input  logic [TRKW-1:0]   wr_track,
  input  logic [DEPTH-1:0]  wr_pat,
  input  logic [LENW-1:0]   wr_len,
  output logic [TRACKS-1:0] gate,
  output logic              step_tick,
  output logic              bar_tick,
  output logic              running
);

  logic fire;

  seq_divider #(.DIVW(DIVW)) u_div (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .run       (run),
    .div       (div),
`ifdef SWING_EN
    .swing_amt (swing_amt),
`endif
    .fire      (fire)
  );

  state_t            state_q;
  logic [DEPTH-1:0]  shd_pat_q [TRACKS];
  logic [DEPTH-1:0]  act_pat_q [TRACKS];
  logic [LENW-1:0]   shd_len_q [TRACKS];
  logic [LENW-1:0]   act_len_q [TRACKS];
  logic [POSW-1:0]   pos_q     [TRACKS];
  logic [POSW-1:0]   gstep_q;
  logic [TRACKS-1:0] gate_q;
  logic              step_q, bar_q, run_q;

  logic              wr_hit;
  logic [LENW-1:0]   wr_len_d;
  logic [DEPTH-1:0]  sel_pat [TRACKS];
  logic [LENW-1:0]   sel_len [TRACKS];
  logic [DEPTH-1:0]  sh_pat  [TRACKS];
  logic [TRACKS-1:0] hit_d, wrap_d;

  assign wr_hit   = wr_en && (32'(wr_track) < TRACKS);
  assign wr_len_d = (wr_len == '0 || 32'(wr_len) > DEPTH) ? LENW'(DEPTH) : wr_len;

  // A track at pos 0 plays straight from its shadow, so a pending update
  // takes effect on the very step it is adopted.
  always_comb begin
    for (int t = 0; t < TRACKS; t++) begin
      sel_pat[t] = (pos_q[t] == '0) ? shd_pat_q[t] : act_pat_q[t];
      sel_len[t] = (pos_q[t] == '0) ? shd_len_q[t] : act_len_q[t];
      sh_pat[t]  = sel_pat[t] << pos_q[t];
      hit_d[t]   = sh_pat[t][DEPTH-1];
      wrap_d[t]  = (LENW'(pos_q[t]) + LENW'(1)) >= sel_len[t];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gstep_q <= '0;
      gate_q  <= '0;
      step_q  <= 1'b0;
      bar_q   <= 1'b0;
      run_q   <= 1'b0;
      for (int t = 0; t < TRACKS; t++) begin
        shd_pat_q[t] <= '0;
        act_pat_q[t] <= '0;
        shd_len_q[t] <= LENW'(DEPTH);
        act_len_q[t] <= LENW'(DEPTH);
        pos_q[t]     <= '0;
      end
    end else begin
      if (!ena) begin
        gate_q <= '0;
        step_q <= 1'b0;
        bar_q  <= 1'b0;
      end else begin
        step_q <= fire;
        bar_q  <= fire && (gstep_q == '0);
        gate_q <= '0;
        case (state_q)
          IDLE: begin
            for (int t = 0; t < TRACKS; t++) begin
              act_pat_q[t] <= shd_pat_q[t];
              act_len_q[t] <= shd_len_q[t];
            end
            if (run) begin
              state_q <= RUN;
              run_q   <= 1'b1;
            end
          end
          RUN: begin
            if (!run) begin
              state_q <= IDLE;
              run_q   <= 1'b0;
              gstep_q <= '0;
              for (int t = 0; t < TRACKS; t++)
                pos_q[t] <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
        if (fire) begin
          gstep_q <= (gstep_q == POSW'(DEPTH - 1)) ? '0 : gstep_q + POSW'(1);
          for (int t = 0; t < TRACKS; t++) begin
            gate_q[t] <= hit_d[t];
            pos_q[t]  <= wrap_d[t] ? '0 : pos_q[t] + POSW'(1);
            if (pos_q[t] == '0) begin
              act_pat_q[t] <= shd_pat_q[t];
              act_len_q[t] <= shd_len_q[t];
            end
          end
        end
      end
      // Shadow writes are accepted even while the enable is low.
      if (wr_hit) begin
        shd_pat_q[wr_track] <= wr_pat;
        shd_len_q[wr_track] <= wr_len_d;
      end
    end
  end

  assign gate      = gate_q;
  assign step_tick = step_q;
  assign bar_tick  = bar_q;
  assign running   = run_q;

endmodule

// File: tb/tb_seq_scheduler.sv
module tb_seq_scheduler;

  logic        clk = 1'b0;
  logic        rst, ena, run, wr_en;
  logic [23:0] div;
  logic [1:0]  wr_track;
  logic [15:0] wr_pat;
  logic [4:0]  wr_len;
  logic [3:0]  gate;
  logic        step_tick, bar_tick, running;

  always #5 clk = ~clk;

  seq_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .run       (run),
    .div       (div),
    .wr_en     (wr_en),
    .wr_track  (wr_track),
    .wr_pat    (wr_pat),
    .wr_len    (wr_len),
    .gate      (gate),
    .step_tick (step_tick),
    .bar_tick  (bar_tick),
    .running   (running)
  );

  typedef struct {
    logic [3:0] gate;
    logic       bar;
    int         gap;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          ticks = 0;
  int          cyc_since = 0;
  int          base;
  logic [15:0] mp_old [4];
  logic [15:0] mp_new [4];
  int          ml     [4];
  int          sw_k   [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected gates for global step k since the last start.
  function automatic logic [3:0] exp_gate(input int k);
    logic [3:0]  g;
    logic [15:0] p;
    g = '0;
    for (int t = 0; t < 4; t++) begin
      p    = (k >= sw_k[t]) ? mp_new[t] : mp_old[t];
      g[t] = p[15 - (k % ml[t])];
    end
    return g;
  endfunction

  task automatic push_steps(input int n, input int gap, input int gap_k, input int gap_v);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.gate = exp_gate(k);
      e.bar  = ((k % 16) == 0);
      e.gap  = (k == 0) ? 0 : ((k == gap_k) ? gap_v : gap);
      sb.push_back(e);
    end
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    cyc_since++;
    if (step_tick) begin
      if (sb.size() == 0)
        check("unexpected_tick", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("gate", 32'(gate), 32'(e.gate));
        check("bar_tick", 32'(bar_tick), 32'(e.bar));
        if (e.gap > 0)
          check("tick_gap", cyc_since, e.gap);
      end
      cyc_since = 0;
      ticks++;
    end else
      check("idle_outputs", 32'({bar_tick, gate}), 32'd0);
  endtask

  task automatic wait_ticks(input int n, input int lim);
    int c;
    c = 0;
    while (ticks < n && c < lim) begin
      cyc();
      c++;
    end
    check("tick_count", ticks, n);
  endtask

  task automatic wr(input logic [1:0] t, input logic [15:0] p, input logic [4:0] l);
    wr_en = 1'b1; wr_track = t; wr_pat = p; wr_len = l;
    cyc();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; run = 1'b0; wr_en = 1'b0;
    div = 24'd4; wr_track = '0; wr_pat = '0; wr_len = '0;
    for (int t = 0; t < 4; t++) begin
      mp_old[t] = '0; mp_new[t] = '0; ml[t] = 16; sw_k[t] = 1000;
    end
    #12;
    check("rst_gate", 32'(gate), 32'd0);
    check("rst_step", 32'(step_tick), 32'd0);
    check("rst_bar", 32'(bar_tick), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Run 1: polymeter, mid-bar rewrite at step 5, enable gap after step 20.
    wr(2'd0, 16'h8888, 5'd16);
    wr(2'd1, 16'hA000, 5'd3);
    mp_old[0] = 16'h8888; mp_new[0] = 16'hF000; sw_k[0] = 16; ml[0] = 16;
    mp_old[1] = 16'hA000; mp_new[1] = 16'hA000; ml[1] = 3;
    push_steps(32, 4, 21, 14);
    run = 1'b1;
    cyc();
    check("running_first_step", 32'(running), 32'd1);
    wait_ticks(6, 40);
    wr(2'd0, 16'hF000, 5'd16);
    wait_ticks(21, 80);
    ena = 1'b0;
    repeat (10) cyc();
    ena = 1'b1;
    wait_ticks(32, 80);
    run = 1'b0;
    cyc();
    check("stopped_running", 32'(running), 32'd0);
    check("run1_drained", sb.size(), 0);

    // Run 2: stop during step 7, then restart from step 0.
    base = ticks;
    mp_old[0] = 16'hF000; sw_k[0] = 1000;
    push_steps(8, 4, -1, 0);
    run = 1'b1;
    wait_ticks(base + 8, 60);
    cyc();
    run = 1'b0;
    check("running_before_stop", 32'(running), 32'd1);
    cyc();
    check("running_after_stop", 32'(running), 32'd0);
    repeat (3) cyc();
    check("run2_drained", sb.size(), 0);
    push_steps(1, 4, -1, 0);
    run = 1'b1;
    cyc();
    check("restart_tick", ticks, base + 9);
    check("restart_running", 32'(running), 32'd1);
    run = 1'b0;
    cyc();

    // Run 3: reset during a gate pulse, then defaults with div=0 and len=0.
    base = ticks;
    push_steps(1, 4, -1, 0);
    run = 1'b1;
    cyc();
    check("pre_reset_tick", ticks, base + 1);
    rst = 1'b1;
    #1;
    check("midrst_gate", 32'(gate), 32'd0);
    check("midrst_step", 32'(step_tick), 32'd0);
    check("midrst_bar", 32'(bar_tick), 32'd0);
    check("midrst_running", 32'(running), 32'd0);
    run = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    for (int t = 0; t < 4; t++) begin
      mp_old[t] = '0; mp_new[t] = '0; ml[t] = 16; sw_k[t] = 1000;
    end
    mp_old[2] = 16'h0001; mp_new[2] = 16'h0001;
    wr(2'd2, 16'h0001, 5'd0);
    div = 24'd0;
    push_steps(32, 1, -1, 0);
    run = 1'b1;
    wait_ticks(base + 33, 80);
    run = 1'b0;
    cyc();
    check("run3_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
